// File: rtl/morse_letter_sequencer_if.sv
// Letter push handshake between the switch/key logic and the Morse sequencer.
interface morse_letter_sequencer_if;
    logic [2:0] letter_in;
    logic       letter_valid;
    logic       letter_ready;

    modport master (output letter_in, output letter_valid, input letter_ready);
    modport slave  (input letter_in, input letter_valid, output letter_ready);
endinterface

// File: rtl/morse_letter_sequencer.sv
// Queues letter selects (I..P) and plays each Morse pattern on one LED with an inter-letter gap.
// Optional MORSE_SEQ_REPEAT_EN: replay the last letter while repeat_en is held and the queue is empty.
module morse_letter_sequencer #(
    parameter int TICK_COUNT = 25000000,
    parameter int GAP_TICKS  = 3,
    parameter int FIFO_DEPTH = 4,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    morse_letter_sequencer_if.slave  lif,
    input  logic                     abort,
`ifdef MORSE_SEQ_REPEAT_EN
    input  logic                     repeat_en,  // "repeat" is a reserved word
`endif
    output logic                     morse_out,
    output logic                     busy,
    output logic                     letter_done,
    output logic [CW-1:0]            fifo_count
);

    localparam int TW = (TICK_COUNT > 2) ? $clog2(TICK_COUNT) : 1;
    localparam int GW = $clog2(GAP_TICKS + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

    state_t          state, state_nxt;
    logic [2:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [15:0]     sr;
    logic [TW-1:0]   tcnt;
    logic [GW-1:0]   gcnt;
    logic [2:0]      cur_letter;
    logic            push, pop, tick, gap_end, have_letter;

    function automatic logic [15:0] pattern(input logic [2:0] l);
        case (l)
            3'd0:    pattern = 16'hA000;
            3'd1:    pattern = 16'hBBB8;
            3'd2:    pattern = 16'hEB80;
            3'd3:    pattern = 16'hBA80;
            3'd4:    pattern = 16'hEE00;
            3'd5:    pattern = 16'hE800;
            3'd6:    pattern = 16'hEEE0;
            default: pattern = 16'hBBA0;
        endcase
    endfunction

    assign have_letter      = (count != '0);
    assign lif.letter_ready = (count != CW'(FIFO_DEPTH));
    assign push             = lif.letter_valid && lif.letter_ready && !abort;
    assign pop              = (state == S_LOAD) && have_letter && !abort;
    assign tick             = (state != S_IDLE) && (tcnt == '0);
    assign gap_end          = (state == S_GAP) && tick && (gcnt == '0);

    assign morse_out   = (state == S_SEND) && sr[15];
    assign busy        = (state != S_IDLE);
    assign letter_done = gap_end && !abort;
    assign fifo_count  = count;

`ifdef MORSE_SEQ_REPEAT_EN
    logic [2:0] last_letter;
    assign cur_letter = have_letter ? fifo_mem[rd_ptr] : last_letter;

    always_ff @(posedge clock) begin
        if (reset || abort)
            last_letter <= '0;
        else if (state == S_LOAD)
            last_letter <= cur_letter;
    end
`else
    assign cur_letter = fifo_mem[rd_ptr];
`endif

    always_ff @(posedge clock) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (have_letter) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_SEND;
            S_SEND: if (tick && (sr[14:0] == '0)) state_nxt = S_GAP;
            S_GAP: begin
                if (gap_end) begin
                    if (have_letter)
                        state_nxt = S_LOAD;
`ifdef MORSE_SEQ_REPEAT_EN
                    else if (repeat_en)
                        state_nxt = S_LOAD;
`endif
                    else
                        state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= lif.letter_in;
    end

    always_ff @(posedge clock) begin
        if (reset || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sr     <= '0;
            tcnt   <= '0;
            gcnt   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            case (state)
                S_LOAD: begin
                    sr   <= pattern(cur_letter);
                    tcnt <= TW'(TICK_COUNT - 1);
                end
                S_SEND: begin
                    tcnt <= tick ? TW'(TICK_COUNT - 1) : tcnt - TW'(1);
                    if (tick) begin
                        // Trailing zeros are never played: the letter ends on its last set bit.
                        if (sr[14:0] == '0)
                            gcnt <= GW'(GAP_TICKS - 1);
                        else
                            sr <= {sr[14:0], 1'b0};
                    end
                end
                S_GAP: begin
                    tcnt <= tick ? TW'(TICK_COUNT - 1) : tcnt - TW'(1);
                    if (tick && (gcnt != '0)) gcnt <= gcnt - GW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Scoreboarded bench: stimulus queues per-letter expectations, a negedge monitor rebuilds each waveform.
module tb_morse_letter_sequencer;
    localparam int TICK = 4;
    localparam int GAP  = 3;
    localparam int DEP  = 4;
    localparam logic [2:0] L_I = 0, L_J = 1, L_K = 2, L_L = 3, L_M = 4, L_N = 5, L_O = 6, L_P = 7;

    typedef struct { logic [15:0] pat; int len; int high; } exp_t;

    // Hand-computed: significant length in ticks and LED-on cycles (on ticks * TICK).
    logic [15:0] PAT  [8] = '{16'hA000, 16'hBBB8, 16'hEB80, 16'hBA80, 16'hEE00, 16'hE800, 16'hEEE0, 16'hBBA0};
    int          LEN  [8] = '{3, 13, 9, 9, 7, 5, 11, 11};
    int          HIGH [8] = '{8, 40, 28, 24, 24, 16, 36, 32};

    logic clock = 0, reset = 1, abort = 0, repeat_en = 0;
    logic morse_out, busy, letter_done;
    logic [2:0] fifo_count;
    int ncmp = 0, nfail = 0, ndone = 0, stray = 0;
    exp_t exp_q[$];

    morse_letter_sequencer_if lif();

    morse_letter_sequencer #(.TICK_COUNT(TICK), .GAP_TICKS(GAP), .FIFO_DEPTH(DEP)) dut (
        .clock(clock), .reset(reset), .lif(lif), .abort(abort),
`ifdef MORSE_SEQ_REPEAT_EN
        .repeat_en(repeat_en),
`endif
        .morse_out(morse_out), .busy(busy), .letter_done(letter_done), .fifo_count(fifo_count));

    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drives one push cycle starting now (caller sits just after a posedge).
    task automatic push(input logic [2:0] l, input bit expect_it);
        lif.letter_in = l;
        lif.letter_valid = 1;
        if (expect_it) exp_q.push_back('{PAT[l], LEN[l], HIGH[l]});
        step(1);
        lif.letter_valid = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin step(1); n++; end
        chk(name, busy, 0);
    endtask

    task automatic wait_high(input string name, input int budget);
        int n = 0;
        while (!morse_out && n < budget) begin step(1); n++; end
        chk(name, morse_out, 1);
    endtask

    // Monitor: samples one bit per tick from the first SEND cycle, compares at each letter_done.
    initial begin
        bit active = 0, start_next = 0, prev_busy = 0, prev_done = 0;
        logic cur = 0;
        int off = 0, nbits = 0, highs = 0, incons = 0;
        logic [31:0] bits = 0, want;
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                active = 0; start_next = 0; prev_busy = 0; prev_done = 0;
            end else begin
                if (start_next) begin
                    active = 1; off = 0; bits = 0; nbits = 0; highs = 0; incons = 0;
                end
                start_next = busy && (!prev_busy || prev_done);
                if (active) begin
                    if (off % TICK == 0) begin
                        bits = {bits[30:0], morse_out}; nbits++; cur = morse_out;
                    end else if (morse_out != cur) incons++;
                    if (morse_out) highs++;
                    off++;
                end else if (morse_out) stray++;
                if (letter_done) begin
                    ndone++;
                    if (exp_q.size() == 0) begin
                        ncmp++; nfail++;
                        $display("FAIL unexpected_done: got letter_done want none (queue empty)");
                    end else begin
                        e = exp_q.pop_front();
                        want = ({16'h0, e.pat} >> (16 - e.len)) << GAP;
                        chk("sb_ticks", nbits, e.len + GAP);
                        chk("sb_wave", int'(bits), int'(want));
                        chk("sb_on_cycles", highs, e.high);
                        chk("sb_tick_stable", incons, 0);
                    end
                    active = 0;
                end
                if (!busy) active = 0;
                prev_busy = busy; prev_done = letter_done;
            end
        end
    end

    initial begin
        int first_done, d0;
        lif.letter_in = 0;
        lif.letter_valid = 0;

        // Reset held two cycles
        reset = 1;
        step(2);
        chk("rst_morse_out", morse_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", lif.letter_ready, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_done", letter_done, 0);
        reset = 0;
        step(1);

        // Single I: exact cycle timing relative to the push edge
        push(L_I, 1);
        first_done = -1;
        for (int k = 0; k <= 26; k++) begin
            if (k == 0)  chk("i_idle_c0", busy, 0);
            if (k == 1)  chk("i_load_busy", busy, 1);
            if (k == 2)  chk("i_dot1_on", morse_out, 1);
            if (k == 5)  chk("i_dot1_end", morse_out, 1);
            if (k == 6)  chk("i_space_off", morse_out, 0);
            if (k == 10) chk("i_dot2_on", morse_out, 1);
            if (k == 14) chk("i_gap_off", morse_out, 0);
            if (letter_done && first_done < 0) first_done = k;
            if (k == 26) chk("i_busy_fall", busy, 0);
            if (k < 26) step(1);
        end
        chk("i_done_cycle", first_done, 25);
        step(2);

        // O then M back to back
        d0 = ndone;
        push(L_O, 1);
        push(L_M, 1);
        wait_idle("om_idle", 400);
        chk("om_done_pulses", ndone - d0, 2);
        step(2);

        // Fill the queue while N plays; fifth push is refused
        push(L_N, 1);
        wait_high("n_send", 50);
        push(L_J, 1);
        push(L_K, 1);
        push(L_L, 1);
        push(L_P, 1);
        chk("full_count", fifo_count, 4);
        chk("full_ready", lif.letter_ready, 0);
        push(L_I, 0);
        chk("full_count_after5", fifo_count, 4);
        wait_idle("full_idle", 2000);
        step(2);

        // Push coincides with LOAD's pop at count=2
        push(L_K, 1);
        push(L_L, 1);
        chk("pp_load_busy", busy, 1);
        chk("pp_count_before", fifo_count, 2);
        push(L_M, 1);
        chk("pp_count_after", fifo_count, 2);
        wait_idle("pp_idle", 1000);
        step(2);

        // Abort mid-SEND of J with three letters queued; same-cycle push is dropped
        push(L_J, 1);
        push(L_K, 0);
        push(L_L, 0);
        push(L_M, 0);
        step(8);
        chk("ab_pre_count", fifo_count, 3);
        chk("ab_pre_busy", busy, 1);
        abort = 1;
        lif.letter_in = L_I;
        lif.letter_valid = 1;
        exp_q.delete();
        step(1);
        abort = 0;
        lif.letter_valid = 0;
        chk("ab_morse_out", morse_out, 0);
        chk("ab_busy", busy, 0);
        chk("ab_count", fifo_count, 0);
        chk("ab_done", letter_done, 0);
        chk("ab_ready", lif.letter_ready, 1);
        step(3);
        chk("ab_push_dropped", busy, 0);

`ifdef MORSE_SEQ_REPEAT_EN
        // K replays while repeat_en is held, ends after the letter in flight once dropped
        begin
            int n = 0;
            repeat_en = 1;
            d0 = ndone;
            push(L_K, 1);
            exp_q.push_back('{PAT[L_K], LEN[L_K], HIGH[L_K]});
            exp_q.push_back('{PAT[L_K], LEN[L_K], HIGH[L_K]});
            while (ndone - d0 < 2 && n < 500) begin step(1); n++; end
            chk("rp_two_done", ndone - d0, 2);
            chk("rp_still_busy", busy, 1);
            repeat_en = 0;
            wait_idle("rp_idle", 300);
            chk("rp_three_done", ndone - d0, 3);
        end
`endif

        step(4);
        chk("queue_drained", exp_q.size(), 0);
        chk("stray_high", stray, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
